// File: rtl/document_writer.sv
// document_writer
//
// Turns a stream of ASCII key codes into word writes into a COLS x ROWS
// character document and keeps track of the cursor.
//
// Optional feature macro: DOC_WRITER_CLEAR_EN
//   defined   : after reset, and whenever form-feed (0x0C) is executed, the
//               whole document is swept with BLANK, one address per cycle.
//   undefined : no clear sweep; busy is tied low and 0x0C is ignored.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous reset, active low
//   key_valid  in   key code offered
//   key_code   in   [7:0] ASCII key code
//   key_ready  out  key accepted when key_valid && key_ready
//   doc_a      out  [8:0] document write address (row*COLS+col)
//   doc_d      out  [7:0] document write data
//   doc_we     out  document write strobe, one word per high cycle
//   cursor     out  [8:0] current cursor address
//   busy       out  high while clearing
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | sweeping BLANK over the document (feature build only)
// ST_IDLE  | waiting for a key, key_ready high
// ST_EXEC  | one cycle: act on the latched key, update cursor
module document_writer #(
   parameter int         COLS  = 20,
   parameter int         ROWS  = 15,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   output logic       key_ready,
   output logic [8:0] doc_a,
   output logic [7:0] doc_d,
   output logic       doc_we,
   output logic [8:0] cursor,
   output logic       busy
);

   localparam int         TOTAL = COLS * ROWS;
   localparam logic [8:0] LAST  = 9'(TOTAL - 1);
   localparam logic [8:0] COLS9 = 9'(COLS);

   if (TOTAL > 512 || TOTAL < 1) begin : g_size_check
      $error("document_writer: COLS*ROWS must be in 1..512");
   end

   localparam logic [7:0] KEY_BS = 8'h08;
   localparam logic [7:0] KEY_CR = 8'h0D;
`ifdef DOC_WRITER_CLEAR_EN
   localparam logic [7:0] KEY_FF = 8'h0C;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;
   localparam state_t ST_RESET = ST_CLEAR;
`else
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;
   localparam state_t ST_RESET = ST_IDLE;
`endif

   state_t     state;
   state_t     state_nxt;
   logic [7:0] key_q;
   logic [8:0] cursor_q;
   logic [8:0] cursor_nxt;
   logic       exec_we;
   logic [8:0] exec_a;
   logic [7:0] exec_d;
   logic [8:0] row_base;
   logic [9:0] row_next;
   logic       is_print;

`ifdef DOC_WRITER_CLEAR_EN
   // Down-counter of sweep words still to write after the current one;
   // the address being written is LAST - sweep_left, so it ascends.
   logic [8:0] sweep_left;
`endif

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_RESET;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (key_valid) begin
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_nxt = ST_IDLE;
`ifdef DOC_WRITER_CLEAR_EN
            if (key_q == KEY_FF) begin
               state_nxt = ST_CLEAR;
            end
`endif
         end
`ifdef DOC_WRITER_CLEAR_EN
         ST_CLEAR: begin
            if (sweep_left == 9'd0) begin
               state_nxt = ST_IDLE;
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Key decode for the EXEC cycle. Enter jumps to the start of the next
   // row: the current row base is found by integer division, then one row
   // is added in 10 bits so a full 512-word document wraps cleanly.
   assign is_print = (key_q >= 8'h20) && (key_q <= 8'h7E);
   assign row_base = 9'((cursor_q / COLS9) * COLS9);
   assign row_next = {1'b0, row_base} + 10'(COLS);

   always_comb begin
      exec_we    = 1'b0;
      exec_a     = cursor_q;
      exec_d     = key_q;
      cursor_nxt = cursor_q;
      if (is_print) begin
         exec_we    = 1'b1;
         cursor_nxt = (cursor_q == LAST) ? 9'd0 : cursor_q + 9'd1;
      end else if (key_q == KEY_BS) begin
         if (cursor_q != 9'd0) begin
            exec_we    = 1'b1;
            exec_a     = cursor_q - 9'd1;
            exec_d     = BLANK;
            cursor_nxt = cursor_q - 9'd1;
         end
      end else if (key_q == KEY_CR) begin
         cursor_nxt = (row_next >= 10'(TOTAL)) ? 9'd0 : row_next[8:0];
      end
   end

   // datapath registers: latched key, cursor, sweep counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_q    <= 8'h00;
         cursor_q <= 9'd0;
`ifdef DOC_WRITER_CLEAR_EN
         sweep_left <= LAST;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (key_valid) begin
                  key_q <= key_code;
               end
            end
            ST_EXEC: begin
               cursor_q <= cursor_nxt;
`ifdef DOC_WRITER_CLEAR_EN
               if (key_q == KEY_FF) begin
                  sweep_left <= LAST;
               end
`endif
            end
`ifdef DOC_WRITER_CLEAR_EN
            ST_CLEAR: begin
               if (sweep_left == 9'd0) begin
                  cursor_q <= 9'd0;
               end else begin
                  sweep_left <= sweep_left - 9'd1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Outputs. Gating with rst makes every output read zero for the whole
   // time reset is held, not just after the first edge, and kills a write
   // the instant reset is asserted mid-cycle.
   always_comb begin
      key_ready = 1'b0;
      doc_we    = 1'b0;
      doc_a     = 9'd0;
      doc_d     = 8'h00;
      busy      = 1'b0;
      if (rst) begin
         case (state)
            ST_IDLE: key_ready = 1'b1;
            ST_EXEC: begin
               doc_we = exec_we;
               if (exec_we) begin
                  doc_a = exec_a;
                  doc_d = exec_d;
               end
            end
`ifdef DOC_WRITER_CLEAR_EN
            ST_CLEAR: begin
               doc_we = 1'b1;
               doc_a  = LAST - sweep_left;
               doc_d  = BLANK;
               busy   = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign cursor = rst ? cursor_q : 9'd0;

endmodule

// File: tb/tb_document_writer.sv
module tb_document_writer;

   logic       clk;
   logic       rst;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ready;
   logic [8:0] doc_a;
   logic [7:0] doc_d;
   logic       doc_we;
   logic [8:0] cursor;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   document_writer dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ready (key_ready),
      .doc_a     (doc_a),
      .doc_d     (doc_d),
      .doc_we    (doc_we),
      .cursor    (cursor),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, miscompares so far %0d", miscompares);
      $fatal(1, "watchdog");
   end

   // Offer one key, wait for it to be accepted, then capture the EXEC cycle.
   task automatic send_key(input logic [7:0] c, output logic wr,
                           output logic [8:0] a, output logic [7:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (!key_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!key_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL send_key_timeout: key_ready=%b required 1", key_ready);
      end
      key_valid = 1'b1;
      key_code  = c;
      @(posedge clk);
      #1 key_valid = 1'b0;
      @(negedge clk);
      wr = doc_we;
      a  = doc_a;
      d  = doc_d;
      @(posedge clk);
   endtask

   // Move the cursor to a target by wrapping to 0 with Enters, then using
   // Enters for whole rows and printable keys for the column.
   task automatic goto_addr(input int target);
      logic wr; logic [8:0] a; logic [7:0] d;
      int n;
      n = 0;
      #1;
      while (cursor != 9'd0 && n < 20) begin
         send_key(8'h0D, wr, a, d);
         #1;
         n++;
      end
      for (int r = 0; r < target / 20; r++) send_key(8'h0D, wr, a, d);
      for (int c = 0; c < target % 20; c++) send_key(8'h7A, wr, a, d);
      @(negedge clk);
   endtask

`ifdef DOC_WRITER_CLEAR_EN
   task automatic check_sweep(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         vectors++;
         if (doc_we !== 1'b1 || doc_d !== 8'h20 || doc_a !== 9'(i) || busy !== 1'b1) begin
            miscompares++;
            if (bad < 5)
               $display("FAIL %s[%0d]: we=%b a=%0d d=%h busy=%b required we=1 a=%0d d=20 busy=1",
                        name, i, doc_we, doc_a, doc_d, busy, i);
            bad++;
         end
         @(negedge clk);
      end
      vectors++;
      if (key_ready !== 1'b1 || cursor !== 9'd0 || busy !== 1'b0 || doc_we !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_end: key_ready=%b cursor=%0d busy=%b we=%b required 1 0 0 0",
                  name, key_ready, cursor, busy, doc_we);
      end
   endtask
`endif

   task automatic test_reset;
      rst = 1'b0;
      key_valid = 1'b1;
      key_code  = 8'h41;
      repeat (3) @(negedge clk);
      vectors++;
      if (key_ready !== 1'b0 || doc_we !== 1'b0 || doc_a !== 9'd0 || doc_d !== 8'h00 ||
          cursor !== 9'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: rdy=%b we=%b a=%0d d=%h cur=%0d busy=%b required all 0",
                  key_ready, doc_we, doc_a, doc_d, cursor, busy);
      end
      key_valid = 1'b0;
      rst = 1'b1;
      #1;
`ifdef DOC_WRITER_CLEAR_EN
      check_sweep("reset_sweep");
`else
      vectors++;
      if (key_ready !== 1'b1 || busy !== 1'b0 || cursor !== 9'd0 || doc_we !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: rdy=%b busy=%b cur=%0d we=%b required 1 0 0 0",
                  key_ready, busy, cursor, doc_we);
      end
`endif
   endtask

   task automatic test_print;
      logic wr; logic [8:0] a; logic [7:0] d;
      send_key(8'h48, wr, a, d);
      vectors++;
      if (wr !== 1'b1 || a !== 9'd0 || d !== 8'h48) begin
         miscompares++;
         $display("FAIL print_H: we=%b a=%0d d=%h required 1 0 48", wr, a, d);
      end
      send_key(8'h69, wr, a, d);
      vectors++;
      if (wr !== 1'b1 || a !== 9'd1 || d !== 8'h69) begin
         miscompares++;
         $display("FAIL print_i: we=%b a=%0d d=%h required 1 1 69", wr, a, d);
      end
      @(negedge clk);
      vectors++;
      if (cursor !== 9'd2 || doc_we !== 1'b0) begin
         miscompares++;
         $display("FAIL print_cursor: cursor=%0d we=%b required 2 0", cursor, doc_we);
      end
      send_key(8'h7E, wr, a, d);
      vectors++;
      if (wr !== 1'b1 || a !== 9'd2 || d !== 8'h7E) begin
         miscompares++;
         $display("FAIL print_tilde: we=%b a=%0d d=%h required 1 2 7e", wr, a, d);
      end
   endtask

   task automatic test_wrap;
      logic wr; logic [8:0] a; logic [7:0] d;
      goto_addr(299);
      vectors++;
      if (cursor !== 9'd299) begin
         miscompares++;
         $display("FAIL wrap_setup: cursor=%0d required 299", cursor);
      end
      send_key(8'h41, wr, a, d);
      @(negedge clk);
      vectors++;
      if (wr !== 1'b1 || a !== 9'd299 || d !== 8'h41 || cursor !== 9'd0) begin
         miscompares++;
         $display("FAIL wrap_A: we=%b a=%0d d=%h cursor=%0d required 1 299 41 0", wr, a, d, cursor);
      end
   endtask

   task automatic test_enter;
      logic wr; logic [8:0] a; logic [7:0] d;
      goto_addr(45);
      send_key(8'h0D, wr, a, d);
      @(negedge clk);
      vectors++;
      if (wr !== 1'b0 || cursor !== 9'd60) begin
         miscompares++;
         $display("FAIL enter_45: we=%b cursor=%0d required 0 60", wr, cursor);
      end
      goto_addr(285);
      send_key(8'h0D, wr, a, d);
      @(negedge clk);
      vectors++;
      if (wr !== 1'b0 || cursor !== 9'd0) begin
         miscompares++;
         $display("FAIL enter_285: we=%b cursor=%0d required 0 0", wr, cursor);
      end
   endtask

   task automatic test_backspace;
      logic wr; logic [8:0] a; logic [7:0] d;
      goto_addr(0);
      send_key(8'h08, wr, a, d);
      @(negedge clk);
      vectors++;
      if (wr !== 1'b0 || cursor !== 9'd0) begin
         miscompares++;
         $display("FAIL bs_at_0: we=%b cursor=%0d required 0 0", wr, cursor);
      end
      goto_addr(21);
      send_key(8'h08, wr, a, d);
      @(negedge clk);
      vectors++;
      if (wr !== 1'b1 || a !== 9'd20 || d !== 8'h20 || cursor !== 9'd20) begin
         miscompares++;
         $display("FAIL bs_at_21: we=%b a=%0d d=%h cursor=%0d required 1 20 20 20", wr, a, d, cursor);
      end
   endtask

   task automatic test_other;
      logic wr; logic [8:0] a; logic [7:0] d;
      logic [7:0] codes [3];
      codes[0] = 8'h01; codes[1] = 8'h7F; codes[2] = 8'h1F;
      goto_addr(7);
      foreach (codes[i]) begin
         send_key(codes[i], wr, a, d);
         @(negedge clk);
         vectors++;
         if (wr !== 1'b0 || cursor !== 9'd7) begin
            miscompares++;
            $display("FAIL other_%h: we=%b cursor=%0d required 0 7", codes[i], wr, cursor);
         end
      end
      send_key(8'h0C, wr, a, d);
`ifdef DOC_WRITER_CLEAR_EN
      vectors++;
      if (wr !== 1'b0) begin
         miscompares++;
         $display("FAIL ff_exec: we=%b required 0", wr);
      end
      #1;
      check_sweep("ff_sweep");
`else
      @(negedge clk);
      vectors++;
      if (wr !== 1'b0 || cursor !== 9'd7 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL ff_ignored: we=%b cursor=%0d busy=%b required 0 7 0", wr, cursor, busy);
      end
`endif
   endtask

   task automatic test_back_to_back;
      int writes;
      int accepts;
      goto_addr(3);
      writes  = 0;
      accepts = 0;
      key_valid = 1'b1;
      key_code  = 8'h62;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (doc_we === 1'b1) writes++;
         if (key_ready === 1'b1) accepts++;
      end
      key_valid = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      if (doc_we === 1'b1) writes++;
      @(negedge clk);
      vectors++;
      if (writes !== 2 || cursor !== 9'd5) begin
         miscompares++;
         $display("FAIL back_to_back: writes=%0d cursor=%0d required 2 5", writes, cursor);
      end
      vectors++;
      if (accepts !== 2) begin
         miscompares++;
         $display("FAIL b2b_ready_cycles: ready_seen=%0d required 2", accepts);
      end
   endtask

   task automatic test_reset_abort;
      int n;
      goto_addr(5);
      key_valid = 1'b1;
      key_code  = 8'h51;
      @(posedge clk);
      #1 key_valid = 1'b0;
      rst = 1'b0;
      #1;
      vectors++;
      if (doc_we !== 1'b0 || cursor !== 9'd0 || key_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_exec: we=%b cursor=%0d rdy=%b required 0 0 0", doc_we, cursor, key_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
`ifdef DOC_WRITER_CLEAR_EN
      for (int i = 0; i < 100; i++) @(negedge clk);
      vectors++;
      if (doc_we !== 1'b1 || doc_a !== 9'd100) begin
         miscompares++;
         $display("FAIL sweep_at_100: we=%b a=%0d required 1 100", doc_we, doc_a);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (doc_we !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_sweep: we=%b busy=%b required 0 0", doc_we, busy);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_sweep("restart_sweep");
`else
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (doc_we !== 1'b0 || cursor !== 9'd0) n++;
      end
      vectors++;
      if (n !== 0) begin
         miscompares++;
         $display("FAIL abort_dropped: bad_cycles=%0d cursor=%0d required 0 0", n, cursor);
      end
`endif
   endtask

   initial begin
      rst       = 1'b0;
      key_valid = 1'b0;
      key_code  = 8'h00;
      test_reset;
      test_print;
      test_wrap;
      test_enter;
      test_backspace;
      test_other;
      test_back_to_back;
      test_reset_abort;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/document_writer.md
DOCUMENT_WRITER -- requirements
Module: document_writer

Interface
REQ-001 SHALL have parameter COLS, default 20, characters per row.
REQ-002 SHALL have parameter ROWS, default 15, rows per document; COLS*ROWS SHALL be at most 512.
REQ-003 SHALL have parameter BLANK, default 8'h20, fill and erase code.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 key_valid  input  1  key code offered.
REQ-007 key_code  input  8  ASCII key code.
REQ-008 key_ready  output  1  key accepted when key_valid && key_ready.
REQ-009 doc_a  output  9  document write address, row*COLS+col.
REQ-010 doc_d  output  8  document write data.
REQ-011 doc_we  output  1  document write strobe, one word per high cycle.
REQ-012 cursor  output  9  current cursor address.
REQ-013 busy  output  1  high while clearing.

Function
REQ-014 SHALL implement FSM states CLEAR, IDLE, EXEC; key_ready SHALL be high only in IDLE.
REQ-015 An accepted key SHALL be latched and the FSM SHALL enter EXEC for exactly one cycle, then return to IDLE; throughput is one key per two cycles.
REQ-016 Printable code 0x20..0x7E in EXEC: doc_we=1, doc_a=cursor, doc_d=code; cursor SHALL advance by 1 at the end of that cycle, wrapping COLS*ROWS-1 -> 0.
REQ-017 Backspace 0x08 in EXEC: if cursor==0, no write and cursor unchanged; otherwise doc_we=1, doc_a=cursor-1, doc_d=BLANK, and cursor becomes cursor-1.
REQ-018 Enter 0x0D in EXEC: no write; cursor SHALL become the first column of the next row, wrapping the last row to 0.
REQ-019 Any other code, including 0x0C without the feature of REQ-027, SHALL be consumed in EXEC with no write and no cursor change.
REQ-020 doc_we SHALL be 0 in IDLE; doc_a and doc_d are don't-care while doc_we=0.
REQ-021 key_valid held high across EXEC SHALL NOT cause a second accept until key_ready is high again.
REQ-022 All cursor arithmetic SHALL be 9-bit; cursor SHALL never hold a value >= COLS*ROWS.

Reset
REQ-023 While rst=0: key_ready=0, doc_we=0, doc_a=0, doc_d=0, cursor=0, busy=0.
REQ-024 After rst deasserts, the FSM SHALL enter CLEAR if DOC_WRITER_CLEAR_EN is defined, otherwise IDLE.
REQ-025 Reset asserted mid-clear or mid-EXEC SHALL abort immediately; any pending key is dropped and no partial write occurs after reset.
REQ-026 cursor SHALL be 0 when the FSM first enters IDLE after reset.

Configuration
REQ-027 With DOC_WRITER_CLEAR_EN defined, CLEAR SHALL write BLANK to addresses 0..COLS*ROWS-1 in ascending order, one per cycle with doc_we=1 and busy=1. It then sets cursor=0 and enters IDLE. CLEAR is entered after reset and when code 0x0C is consumed in EXEC.
REQ-028 Without DOC_WRITER_CLEAR_EN, the CLEAR state and sweep counter SHALL be absent, busy SHALL be tied 0, and 0x0C SHALL follow REQ-019.

Verification
REQ-029 With the macro defined, release reset: 300 consecutive cycles with doc_we=1 and doc_d=8'h20, doc_a 0..299, then key_ready=1, cursor=0, busy=0.
REQ-030 From cursor=0, send 'H','i' (0x48, 0x69): writes (0,0x48), (1,0x69); cursor=2.
REQ-031 From cursor=299, send 'A': write (299,0x41); cursor=0.
REQ-032 From cursor=45, send 0x0D: no doc_we; cursor=60. From cursor=285, send 0x0D: cursor=0.
REQ-033 From cursor=0, send 0x08: no write, cursor=0. From cursor=21, send 0x08: write (20,0x20), cursor=20.
REQ-034 Assert rst at cycle 100 of a clear sweep: doc_we drops to 0 at once. Release reset: the sweep restarts at address 0.
